game_timer_ctrl: RTL and testbench

GAME_TIMER_CTRL -- requirements
Module: game_timer_ctrl

---
 rtl/game_timer_ctrl_if.sv | 29 ++
 rtl/game_timer_ctrl.sv | 127 ++++++++++++
 tb/tb_game_timer_ctrl.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/game_timer_ctrl_if.sv
// Game timer control bus.
// Requests in, timer status out.
interface game_timer_ctrl_if;
  logic        start;
  logic        pause;
  logic        resume;
  logic        stop;
  logic [15:0] time_limit;
  logic [15:0] elapsed;
  logic [15:0] remaining;
  logic        tick;
  logic        running;
  logic        expired;
  logic [1:0]  state;

  modport master (
    output start, pause, resume, stop,
    output time_limit,
    input  elapsed, remaining, tick,
    input  running, expired, state
  );

  modport slave (
    input  start, pause, resume, stop,
    input  time_limit,
    output elapsed, remaining, tick,
    output running, expired, state
  );
endinterface

// File: rtl/game_timer_ctrl.sv
// Game-second timer with start/pause/resume/stop
// control, optional limit and expiry.
module game_timer_ctrl #(
  parameter int unsigned TICK_DIV = 100000000
) (
  input  logic              clk,
  input  logic              reset,
  game_timer_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  localparam logic [31:0] WRAP_AT = 32'(TICK_DIV - 1);

  state_t      state_q;
  state_t      state_d;
  logic [31:0] pre_q;
  logic [31:0] pre_d;
  logic [15:0] elapsed_q;
  logic [15:0] elapsed_d;
  logic [15:0] limit_q;
  logic [15:0] limit_d;
  logic        tick_q;
  logic        tick_d;
  logic        count_en;
  logic        wrap;
  logic        saturated;
  logic        hit_limit;

  assign wrap      = (pre_q == WRAP_AT);
  assign saturated = (limit_q == 16'd0) &&
                     (elapsed_q == 16'hFFFF);
  assign hit_limit = (limit_q != 16'd0) &&
                     ((elapsed_q + 16'd1) == limit_q);

  // Next state: highest-priority request wins;
  // an expiring wrap overrides a pause.
  always_comb begin
    state_d   = state_q;
    pre_d     = pre_q;
    elapsed_d = elapsed_q;
    limit_d   = limit_q;
    tick_d    = 1'b0;
    count_en  = 1'b0;
    priority case (1'b1)
      bus.stop: begin
        state_d   = IDLE;
        pre_d     = 32'd0;
        elapsed_d = 16'd0;
        limit_d   = 16'd0;
      end
      bus.start: begin
        if (state_q != RUNNING) begin
          state_d   = RUNNING;
          pre_d     = 32'd0;
          elapsed_d = 16'd0;
          limit_d   = bus.time_limit;
        end else begin
          count_en = 1'b1;
        end
      end
      bus.pause: begin
        if (state_q == RUNNING &&
            !(wrap && hit_limit)) begin
          state_d = PAUSED;
        end else begin
          count_en = (state_q == RUNNING);
        end
      end
      bus.resume: begin
        if (state_q == PAUSED) begin
          state_d = RUNNING;
        end else begin
          count_en = (state_q == RUNNING);
        end
      end
      default: begin
        count_en = (state_q == RUNNING);
      end
    endcase
    if (count_en) begin
      if (wrap) begin
        pre_d = 32'd0;
        if (!saturated) begin
          elapsed_d = elapsed_q + 16'd1;
          tick_d    = 1'b1;
          if (hit_limit) begin
            state_d = EXPIRED;
          end
        end
      end else begin
        pre_d = pre_q + 32'd1;
      end
    end
  end

  // State and counters; reset clears everything.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      pre_q     <= 32'd0;
      elapsed_q <= 16'd0;
      limit_q   <= 16'd0;
      tick_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pre_q     <= pre_d;
      elapsed_q <= elapsed_d;
      limit_q   <= limit_d;
      tick_q    <= tick_d;
    end
  end

  assign bus.elapsed   = elapsed_q;
  assign bus.remaining = (limit_q > elapsed_q) ?
                         (limit_q - elapsed_q) : 16'd0;
  assign bus.tick      = tick_q;
  assign bus.running   = (state_q == RUNNING);
  assign bus.expired   = (state_q == EXPIRED);
  assign bus.state     = state_q;

endmodule

// File: tb/tb_game_timer_ctrl.sv
// Directed bench for game_timer_ctrl:
// scoreboard of expected status per step.
module tb_game_timer_ctrl;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  game_timer_ctrl_if ia ();
  game_timer_ctrl_if ib ();

  game_timer_ctrl #(.TICK_DIV(4)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (ia)
  );

  game_timer_ctrl #(.TICK_DIV(2)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (ib)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    bit          use_b;
    logic [15:0] el;
    logic [15:0] rem;
    logic        tk;
    logic        run;
    logic        ex;
    logic [1:0]  st;
  } exp_t;

  exp_t sbq[$];

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag,
                      input bit use_b,
                      input logic [15:0] el,
                      input logic [15:0] rem,
                      input logic tk,
                      input logic [1:0] st);
    exp_t e;
    e.tag   = tag;
    e.use_b = use_b;
    e.el    = el;
    e.rem   = rem;
    e.tk    = tk;
    e.run   = (st == 2'd1);
    e.ex    = (st == 2'd3);
    e.st    = st;
    sbq.push_back(e);
  endtask

  task automatic cmp(input string tag,
                     input string fld,
                     input logic [15:0] got,
                     input logic [15:0] want);
    vectors++;
    assert (got === want) else begin
      miscompares++;
      $error("FAIL %s %s: got %0h want %0h",
             tag, fld, got, want);
    end
  endtask

  task automatic check();
    exp_t e;
    if (sbq.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL scoreboard: queue empty");
      return;
    end
    e = sbq.pop_front();
    if (!e.use_b) begin
      cmp(e.tag, "elapsed", ia.elapsed, e.el);
      cmp(e.tag, "remaining", ia.remaining, e.rem);
      cmp(e.tag, "tick", 16'(ia.tick), 16'(e.tk));
      cmp(e.tag, "running", 16'(ia.running),
          16'(e.run));
      cmp(e.tag, "expired", 16'(ia.expired),
          16'(e.ex));
      cmp(e.tag, "state", 16'(ia.state), 16'(e.st));
    end else begin
      cmp(e.tag, "elapsed", ib.elapsed, e.el);
      cmp(e.tag, "remaining", ib.remaining, e.rem);
      cmp(e.tag, "tick", 16'(ib.tick), 16'(e.tk));
      cmp(e.tag, "running", 16'(ib.running),
          16'(e.run));
      cmp(e.tag, "expired", 16'(ib.expired),
          16'(e.ex));
      cmp(e.tag, "state", 16'(ib.state), 16'(e.st));
    end
  endtask

  task automatic exp_a(input string tag,
                       input logic [15:0] el,
                       input logic [15:0] rem,
                       input logic tk,
                       input logic [1:0] st);
    push(tag, 1'b0, el, rem, tk, st);
    check();
  endtask

  task automatic exp_b(input string tag,
                       input logic [15:0] el,
                       input logic [15:0] rem,
                       input logic tk,
                       input logic [1:0] st);
    push(tag, 1'b1, el, rem, tk, st);
    check();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset = 1'b0;
    ia.start = 0; ia.pause = 0;
    ia.resume = 0; ia.stop = 0;
    ia.time_limit = 16'd0;
    ib.start = 0; ib.pause = 0;
    ib.resume = 0; ib.stop = 0;
    ib.time_limit = 16'd0;

    cyc(2);
    exp_a("reset", 0, 0, 0, 0);
    exp_b("reset_b", 0, 0, 0, 0);

    // limited run of 3 seconds
    reset = 1'b1;
    ia.time_limit = 16'd3;
    ia.start = 1;
    cyc(1);
    ia.start = 0;
    ia.time_limit = 16'd99;
    exp_a("lim_start", 0, 3, 0, 1);
    cyc(3);
    exp_a("lim_pre_tick1", 0, 3, 0, 1);
    cyc(1);
    exp_a("lim_tick1", 1, 2, 1, 1);
    ia.start = 1;
    ia.time_limit = 16'd9;
    cyc(1);
    ia.start = 0;
    exp_a("start_in_run", 1, 2, 0, 1);
    cyc(3);
    exp_a("lim_tick2", 2, 1, 1, 1);
    cyc(4);
    exp_a("lim_expire", 3, 0, 1, 3);
    cyc(1);
    exp_a("lim_hold", 3, 0, 0, 3);

    // unlimited run with pause/resume
    ia.time_limit = 16'd0;
    ia.start = 1;
    cyc(1);
    ia.start = 0;
    exp_a("unl_start", 0, 0, 0, 1);
    cyc(6);
    exp_a("unl_run6", 1, 0, 0, 1);
    ia.pause = 1;
    cyc(1);
    ia.pause = 0;
    exp_a("unl_paused", 1, 0, 0, 2);
    cyc(10);
    exp_a("unl_hold", 1, 0, 0, 2);
    ia.resume = 1;
    cyc(1);
    ia.resume = 0;
    exp_a("unl_resume", 1, 0, 0, 1);
    cyc(1);
    exp_a("unl_res_pre", 1, 0, 0, 1);
    cyc(1);
    exp_a("unl_res_tick", 2, 0, 1, 1);

    // stop beats start and pause
    ia.start = 1; ia.stop = 1; ia.pause = 1;
    cyc(1);
    ia.start = 0; ia.stop = 0; ia.pause = 0;
    exp_a("stop_prio", 0, 0, 0, 0);

    // pause on the wrap edge
    ia.start = 1;
    cyc(1);
    ia.start = 0;
    cyc(3);
    exp_a("wrap_pre", 0, 0, 0, 1);
    ia.pause = 1;
    cyc(1);
    ia.pause = 0;
    exp_a("wrap_pause", 0, 0, 0, 2);
    cyc(1);
    exp_a("wrap_no_tick", 0, 0, 0, 2);
    ia.stop = 1;
    cyc(1);
    ia.stop = 0;
    exp_a("stop_paused", 0, 0, 0, 0);

    // expiry beats a coincident pause
    ia.time_limit = 16'd1;
    ia.start = 1;
    cyc(1);
    ia.start = 0;
    cyc(3);
    ia.pause = 1;
    cyc(1);
    ia.pause = 0;
    exp_a("exp_vs_pause", 1, 0, 1, 3);

    // reset mid-run
    ia.time_limit = 16'd10;
    ia.start = 1;
    cyc(1);
    ia.start = 0;
    cyc(20);
    exp_a("mid_el5", 5, 5, 1, 1);
    reset = 1'b0;
    cyc(1);
    exp_a("mid_reset", 0, 0, 0, 0);
    reset = 1'b1;
    ia.time_limit = 16'd0;
    ia.start = 1;
    cyc(1);
    ia.start = 0;
    exp_a("post_rst_start", 0, 0, 0, 1);
    cyc(4);
    exp_a("post_rst_tick", 1, 0, 1, 1);

    // saturation on the TICK_DIV=2 instance
    ib.time_limit = 16'd0;
    ib.start = 1;
    cyc(1);
    ib.start = 0;
    exp_b("sat_start", 0, 0, 0, 1);
    force dut_b.elapsed_q = 16'hFFFD;
    #1;
    release dut_b.elapsed_q;
    cyc(2);
    exp_b("sat_fffe", 16'hFFFE, 0, 1, 1);
    cyc(2);
    exp_b("sat_ffff", 16'hFFFF, 0, 1, 1);
    cyc(1);
    exp_b("sat_after", 16'hFFFF, 0, 0, 1);
    cyc(1);
    exp_b("sat_wrap", 16'hFFFF, 0, 0, 1);
    cyc(10);
    exp_b("sat_hold", 16'hFFFF, 0, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
